sid_register_bank: RTL and testbench
====================================

// Module: sid_register_bank
// PURPOSE
// CPU-side register file for one SID chip; it is the writer end of the voice register interface.
// Captures bus writes to $00-$18 and drives freq/pw/control/ADSR for voices 1-3, plus the filter/volume regs.
// Returns OSC3/ENV3/POTX/POTY on reads. Models the SID data-bus latch, whose last value decays to $00.
// PARAMETERS
// DECAY_CYCLES  20'hA2000  ce_1m ticks before the bus latch fades to 0 (8580 timing)
// CNT_W         20         width of the decay counter; must hold DECAY_CYCLES
// PORTS
// clock        in   1   system clock; the only clock
// reset_n      in   1   asynchronous, active-low reset
// ce_1m        in   1   1 MHz clock enable; advances the decay counter only
// cs           in   1   chip select; one access per clock while high
// we           in   1   1=write, 0=read (qualified by cs)
// addr         in   5   register address $00-$1F
// wdata        in   8   write data
// rdata        out  8   registered read data
// osc3, env3   in   8   voice-3 osc_out/env_out readback
// potx, poty   in   8   paddle values
// freq_lo/hi_v[1..3]    out 8 each   voice frequency ($00/$01, +7 per voice)
// pw_lo_v[1..3] out 8, pw_hi_v[1..3] out 4   pulse width ($02/$03)
// control_v[1..3], att_dec_v[1..3], sus_rel_v[1..3]   out 8 each   ($04/$05/$06)
// fc_lo out 3, fc_hi out 8, res_filt out 8, mode_vol out 8   ($15-$18)
// BEHAVIOUR
// - Reset (reset_n low, async): every register output, rdata, bus latch and decay counter = 0.
// - Write (cs&we): at the clock edge, addr $00-$18 updates its register; pw_hi keeps wdata[3:0], fc_lo wdata[2:0].
//   Writes to $19-$1F change no register. Every write loads bus latch <= wdata (full byte).
// - Writes do not depend on ce_1m; the register output changes the cycle after the edge (no extra latency).
// - Read (cs&!we): rdata is valid on the clock after the access edge (latency 1), held until the next read.
//   $19=potx, $1A=poty, $1B=osc3, $1C=env3; these also load bus latch with the returned value.
//   $00-$18 and $1D-$1F are write-only: they return the bus latch and leave it unchanged.
// - Decay: every access reloads counter <= DECAY_CYCLES.
//   On ce_1m with counter!=0, counter decrements; the 1->0 step clears the bus latch to $00.
//   counter==0 holds. An access in the same cycle as a ce_1m tick: reload wins, no decrement.
// - Read-after-write to the same address is back-to-back: the readback uses the latch value written the cycle before.
// - Register outputs are plain flops; no glitch on a read; no handshake stall (always ready).
// - reset_n asserted mid-access: the access is discarded; state = reset values.
// STRUCTURE
// - sid_regs_pkg: localparams for register addresses (VOICE_STRIDE=7, REG_FC_LO=$15 .. REG_ENV3=$1C).
// - sub-module sid_bus_decay: latch + CNT_W counter; inputs load, load_val, ce_1m; output latch.
// - Top: write decoder, 25-entry register array, read mux, rdata flop.
// TESTING
// - Reset: pulse reset_n low mid-stream -> all outputs 0 immediately; rdata 0.
// - Write $07=$34, $08=$12 -> freq_lo_v2=$34, freq_hi_v2=$12; voices 1 and 3 unchanged.
// - Write $03=$AB -> pw_hi_v1=$B; read $03 next cycle -> rdata=$AB (bus latch).
// - Read $1B with osc3=$5A -> rdata=$5A one cycle later.
//   Then DECAY_CYCLES-1 ce_1m ticks: read $00 -> $5A; at tick DECAY_CYCLES: read -> $00.
// - Write $1C=$FF -> env3 output path unaffected; read $1C returns env3, not $FF.
// - Access coincident with the final ce_1m tick -> latch kept, counter reloaded to DECAY_CYCLES.

Source files
------------

// File: rtl/sid_regs_pkg.sv
// sid_regs_pkg: SID register map constants and the per-register write mask.
package sid_regs_pkg;
  localparam int NUM_REGS = 25;
  localparam int VOICE_STRIDE = 7;
  localparam logic [4:0] REG_FREQ_LO = 5'h00;
  localparam logic [4:0] REG_FREQ_HI = 5'h01;
  localparam logic [4:0] REG_PW_LO = 5'h02;
  localparam logic [4:0] REG_PW_HI = 5'h03;
  localparam logic [4:0] REG_CONTROL = 5'h04;
  localparam logic [4:0] REG_ATT_DEC = 5'h05;
  localparam logic [4:0] REG_SUS_REL = 5'h06;
  localparam logic [4:0] REG_FC_LO = 5'h15;
  localparam logic [4:0] REG_FC_HI = 5'h16;
  localparam logic [4:0] REG_RES_FILT = 5'h17;
  localparam logic [4:0] REG_MODE_VOL = 5'h18;
  localparam logic [4:0] REG_POTX = 5'h19;
  localparam logic [4:0] REG_POTY = 5'h1A;
  localparam logic [4:0] REG_OSC3 = 5'h1B;
  localparam logic [4:0] REG_ENV3 = 5'h1C;
  // Narrow registers store only their implemented bits so the upper bits stay zero.
  function automatic logic [7:0] write_mask(input logic [4:0] a);
    return a == REG_FC_LO ? 8'h07 :
           (a == REG_PW_HI || a == 5'(REG_PW_HI + VOICE_STRIDE) ||
            a == 5'(REG_PW_HI + 2 * VOICE_STRIDE)) ? 8'h0F : 8'hFF;
  endfunction
endpackage

// File: rtl/sid_bus_decay.sv
// sid_bus_decay: data-bus latch that fades to $00 after DECAY_CYCLES ce_1m ticks without an access.
module sid_bus_decay #(
  parameter int CNT_W = 20,
  parameter logic [CNT_W-1:0] DECAY_CYCLES = 20'hA2000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ce_1m,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] latch
);
  logic [CNT_W-1:0] cnt;
  // Any access reloads the counter and wins over a coincident tick; the 1->0 tick clears the latch.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      latch <= 8'h00;
    end else if (load) begin
      cnt <= DECAY_CYCLES;
      latch <= load_val;
    end else if (ce_1m && cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) latch <= 8'h00;
    end
endmodule

// File: rtl/sid_register_bank.sv
// sid_register_bank: CPU-side SID register file with readback mux and decaying bus latch.
module sid_register_bank
  import sid_regs_pkg::*;
#(
  parameter int CNT_W = 20,
  parameter logic [CNT_W-1:0] DECAY_CYCLES = 20'hA2000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ce_1m,
  input  logic       cs,
  input  logic       we,
  input  logic [4:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic [7:0] osc3,
  input  logic [7:0] env3,
  input  logic [7:0] potx,
  input  logic [7:0] poty,
  output logic [7:0] freq_lo_v1, freq_hi_v1, pw_lo_v1, control_v1, att_dec_v1, sus_rel_v1,
  output logic [7:0] freq_lo_v2, freq_hi_v2, pw_lo_v2, control_v2, att_dec_v2, sus_rel_v2,
  output logic [7:0] freq_lo_v3, freq_hi_v3, pw_lo_v3, control_v3, att_dec_v3, sus_rel_v3,
  output logic [3:0] pw_hi_v1, pw_hi_v2, pw_hi_v3,
  output logic [2:0] fc_lo,
  output logic [7:0] fc_hi,
  output logic [7:0] res_filt,
  output logic [7:0] mode_vol
);
  localparam int V2 = VOICE_STRIDE;
  localparam int V3 = 2 * VOICE_STRIDE;
  logic [7:0] regs [NUM_REGS];
  logic [7:0] latch, rd_val, load_val;
  logic       rd_port;
  // Readable ports return live inputs; every other address reflects the bus latch.
  always_comb begin
    rd_port = addr >= REG_POTX && addr <= REG_ENV3;
    rd_val = addr == REG_POTX ? potx :
             addr == REG_POTY ? poty :
             addr == REG_OSC3 ? osc3 :
             addr == REG_ENV3 ? env3 : latch;
    load_val = we ? wdata : rd_val;
  end
  // Register array captures writes to $00-$18; higher addresses are ignored.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else if (cs && we && addr <= REG_MODE_VOL) begin
      regs[addr] <= wdata & write_mask(addr);
    end
  // Read data is registered and held until the next read.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) rdata <= 8'h00;
    else if (cs && !we) rdata <= rd_val;
  sid_bus_decay #(.CNT_W(CNT_W), .DECAY_CYCLES(DECAY_CYCLES)) u_decay (
    .clock(clock), .reset_n(reset_n), .ce_1m(ce_1m),
    .load(cs && (we || rd_port) || cs), .load_val(load_val), .latch(latch)
  );
  assign freq_lo_v1 = regs[REG_FREQ_LO];
  assign freq_hi_v1 = regs[REG_FREQ_HI];
  assign pw_lo_v1 = regs[REG_PW_LO];
  assign pw_hi_v1 = regs[REG_PW_HI][3:0];
  assign control_v1 = regs[REG_CONTROL];
  assign att_dec_v1 = regs[REG_ATT_DEC];
  assign sus_rel_v1 = regs[REG_SUS_REL];
  assign freq_lo_v2 = regs[REG_FREQ_LO + V2];
  assign freq_hi_v2 = regs[REG_FREQ_HI + V2];
  assign pw_lo_v2 = regs[REG_PW_LO + V2];
  assign pw_hi_v2 = regs[REG_PW_HI + V2][3:0];
  assign control_v2 = regs[REG_CONTROL + V2];
  assign att_dec_v2 = regs[REG_ATT_DEC + V2];
  assign sus_rel_v2 = regs[REG_SUS_REL + V2];
  assign freq_lo_v3 = regs[REG_FREQ_LO + V3];
  assign freq_hi_v3 = regs[REG_FREQ_HI + V3];
  assign pw_lo_v3 = regs[REG_PW_LO + V3];
  assign pw_hi_v3 = regs[REG_PW_HI + V3][3:0];
  assign control_v3 = regs[REG_CONTROL + V3];
  assign att_dec_v3 = regs[REG_ATT_DEC + V3];
  assign sus_rel_v3 = regs[REG_SUS_REL + V3];
  assign fc_lo = regs[REG_FC_LO][2:0];
  assign fc_hi = regs[REG_FC_HI];
  assign res_filt = regs[REG_RES_FILT];
  assign mode_vol = regs[REG_MODE_VOL];
endmodule

// File: tb/tb_sid_register_bank.sv
// tb_sid_register_bank: scoreboard bench for register writes, readback latency and bus-latch decay.
module tb_sid_register_bank;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] DECAY = 8'd20;
  logic clock = 1'b0, reset_n = 1'b0, ce_1m = 1'b0, cs = 1'b0, we = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] wdata = '0, osc3 = '0, env3 = '0, potx = '0, poty = '0, rdata;
  logic [7:0] freq_lo_v1, freq_hi_v1, pw_lo_v1, control_v1, att_dec_v1, sus_rel_v1;
  logic [7:0] freq_lo_v2, freq_hi_v2, pw_lo_v2, control_v2, att_dec_v2, sus_rel_v2;
  logic [7:0] freq_lo_v3, freq_hi_v3, pw_lo_v3, control_v3, att_dec_v3, sus_rel_v3;
  logic [3:0] pw_hi_v1, pw_hi_v2, pw_hi_v3;
  logic [2:0] fc_lo;
  logic [7:0] fc_hi, res_filt, mode_vol;
  int vectors = 0, miscompares = 0;
  logic [7:0] sb [$];
  logic rd_seen;

  sid_register_bank #(.CNT_W(CNT_W), .DECAY_CYCLES(DECAY)) dut (
    .clock(clock), .reset_n(reset_n), .ce_1m(ce_1m), .cs(cs), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .osc3(osc3), .env3(env3), .potx(potx), .poty(poty),
    .freq_lo_v1(freq_lo_v1), .freq_hi_v1(freq_hi_v1), .pw_lo_v1(pw_lo_v1), .control_v1(control_v1),
    .att_dec_v1(att_dec_v1), .sus_rel_v1(sus_rel_v1),
    .freq_lo_v2(freq_lo_v2), .freq_hi_v2(freq_hi_v2), .pw_lo_v2(pw_lo_v2), .control_v2(control_v2),
    .att_dec_v2(att_dec_v2), .sus_rel_v2(sus_rel_v2),
    .freq_lo_v3(freq_lo_v3), .freq_hi_v3(freq_hi_v3), .pw_lo_v3(pw_lo_v3), .control_v3(control_v3),
    .att_dec_v3(att_dec_v3), .sus_rel_v3(sus_rel_v3),
    .pw_hi_v1(pw_hi_v1), .pw_hi_v2(pw_hi_v2), .pw_hi_v3(pw_hi_v3),
    .fc_lo(fc_lo), .fc_hi(fc_hi), .res_filt(res_filt), .mode_vol(mode_vol)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reads are scored one cycle after their access edge.
  always @(posedge clock) begin
    rd_seen = cs && !we && reset_n;
    #1;
    if (rd_seen && sb.size() != 0) chk("rdata", rdata, sb.pop_front());
  end

  task automatic wr(input logic [4:0] a, input logic [7:0] d, input logic c = 1'b0);
    @(negedge clock);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d; ce_1m = c;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] e, input logic c = 1'b0);
    @(negedge clock);
    cs = 1'b1; we = 1'b0; addr = a; ce_1m = c;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input logic c = 1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cs = 1'b0; we = 1'b0; ce_1m = c;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_freq_lo_v1", freq_lo_v1, 8'h00);
    chk("rst_mode_vol", mode_vol, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    wr(5'h07, 8'h34);
    wr(5'h08, 8'h12);
    idle(1);
    chk("freq_lo_v2", freq_lo_v2, 8'h34);
    chk("freq_hi_v2", freq_hi_v2, 8'h12);
    chk("freq_lo_v1", freq_lo_v1, 8'h00);
    chk("freq_hi_v3", freq_hi_v3, 8'h00);
    wr(5'h03, 8'hAB);
    rd(5'h03, 8'hAB);
    wr(5'h15, 8'hFF);
    wr(5'h12, 8'h41);
    wr(5'h18, 8'h1F);
    wr(5'h11, 8'hC7);
    idle(1);
    chk("pw_hi_v1", pw_hi_v1, 4'hB);
    chk("fc_lo", fc_lo, 3'h7);
    chk("control_v3", control_v3, 8'h41);
    chk("mode_vol", mode_vol, 8'h1F);
    chk("pw_hi_v3", pw_hi_v3, 4'h7);
    chk("pw_hi_v2", pw_hi_v2, 4'h0);
    osc3 = 8'h5A;
    rd(5'h1B, 8'h5A);
    idle(int'(DECAY) - 1, 1'b1);
    rd(5'h00, 8'h5A);
    idle(int'(DECAY), 1'b1);
    rd(5'h00, 8'h00);
    env3 = 8'h33; potx = 8'h66; poty = 8'h77;
    wr(5'h1C, 8'hFF);
    rd(5'h1C, 8'h33);
    rd(5'h1D, 8'h33);
    rd(5'h1A, 8'h77);
    rd(5'h19, 8'h66);
    idle(int'(DECAY) - 1, 1'b1);
    rd(5'h00, 8'h66, 1'b1);
    idle(int'(DECAY) - 1, 1'b1);
    rd(5'h00, 8'h66);
    idle(int'(DECAY) - 1, 1'b1);
    wr(5'h1F, 8'h99, 1'b1);
    idle(int'(DECAY) - 1, 1'b1);
    rd(5'h1D, 8'h99);
    idle(int'(DECAY), 1'b1);
    rd(5'h00, 8'h00);
    idle(2);
    chk("mode_vol_after_high_wr", mode_vol, 8'h1F);
    wr(5'h07, 8'h55);
    rd(5'h1B, 8'h5A);
    idle(1);
    chk("freq_lo_v2_b", freq_lo_v2, 8'h55);
    chk("rdata_b", rdata, 8'h5A);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_freq_lo_v2", freq_lo_v2, 8'h00);
    chk("midrst_rdata", rdata, 8'h00);
    chk("midrst_mode_vol", mode_vol, 8'h00);
    wr(5'h08, 8'h77);
    @(negedge clock);
    cs = 1'b0;
    reset_n = 1'b1;
    idle(1);
    chk("rst_discard_wr", freq_hi_v2, 8'h00);
    rd(5'h00, 8'h00);
    idle(2);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
